// File: rtl/mux_n_1_stream_pkg.sv
// mux_pkg: arbitration mode constants and FSM state encoding shared by stream muxes
package mux_pkg;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;
    localparam int MODE_SEL   = 2;
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;
endpackage

// File: rtl/mux_n_1_stream_rr_arbiter.sv
// rr_arbiter: combinational channel picker (round-robin from base, fixed lowest-first, or direct select)
// ports: req - request vector; base - rr pointer or select value; mode - MODE_* constant;
//        found - a request was picked; idx - picked channel
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] base,
    input  logic [1:0]    mode,
    output logic          found,
    output logic [SW-1:0] idx
);
    logic [SW-1:0] start;
    logic [N-1:0]  rot;
    logic [SW:0]   sum;
    always_comb begin
        start = mode == 2'(MODE_RR) ? base : '0;
        rot   = N'({req, req} >> start);
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        if (mode == 2'(MODE_SEL)) begin
            // base values >= N match no channel and therefore never request
            idx = base;
            for (int i = 0; i < N; i++)
                if (base == SW'(i)) found = req[i];
        end else begin
            // descending scan so the nearest set bit above start wins
            for (int i = N - 1; i >= 0; i--)
                if (rot[i]) begin
                    found = 1'b1;
                    sum   = {1'b0, start} + (SW+1)'(i);
                    idx   = sum >= (SW+1)'(N) ? SW'(sum - (SW+1)'(N)) : sum[SW-1:0];
                end
        end
    end
endmodule

// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: N:1 valid/ready stream mux with packet locking and registered output
// ports: in_data/in_valid/in_last/in_ready - N producer channels; sel - channel select (MODE 2);
//        out_data/out_valid/out_last/out_ready - registered consumer side; grant - locked channel;
//        busy - packet locked; clk, rst_n - clock and synchronous active-low reset
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic [SW-1:0]   grant,
    output logic            busy
);
    state_t        state_q, state_d;
    logic [SW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, idx;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          found, take, xfer;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req   (in_valid),
        .base  (MODE == MODE_SEL ? sel : rr_ptr_q),
        .mode  (2'(MODE)),
        .found (found),
        .idx   (idx)
    );

    // output register can accept when empty or draining this cycle
    assign take     = !out_valid_q || out_ready;
    assign xfer     = state_q == ST_LOCK && in_valid[grant_q] && take;
    assign in_ready = state_q == ST_LOCK && take ? N'(1) << grant_q : '0;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;
        if (state_q == ST_IDLE && found) begin
            state_d = ST_LOCK;
            grant_d = idx;
        end
        if (xfer) begin
            out_data_d  = in_data[grant_q*W +: W];
            out_last_d  = in_last[grant_q];
            out_valid_d = 1'b1;
            if (in_last[grant_q]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = MODE == MODE_RR ? (grant_q == SW'(N-1) ? '0 : grant_q + 1'b1) : rr_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign grant     = grant_q;
    assign busy      = state_q == ST_LOCK;
endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream: self-checking bench for the three arbitration modes against a packet-level model
module tb_mux_n_1_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ordy;
    logic [4:0]  iv, il;
    logic [39:0] id;
    logic [2:0]  sel;
    int          m;

    logic [7:0] od0, od1, od2, od;
    logic       ov0, ov1, ov2, ol0, ol1, ol2, b0, b1, b2, ov, ol, bsy;
    logic [1:0] g0, g1;
    logic [2:0] g2, gnt;
    logic [3:0] r0, r1;
    logic [4:0] r2, rdy;

    mux_n_1_stream #(.N(4), .W(8), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(id[31:0]), .in_valid(m == 0 ? iv[3:0] : 4'b0),
        .in_last(il[3:0]), .in_ready(r0), .sel(sel[1:0]), .out_data(od0), .out_valid(ov0),
        .out_last(ol0), .out_ready(ordy), .grant(g0), .busy(b0));
    mux_n_1_stream #(.N(4), .W(8), .MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_data(id[31:0]), .in_valid(m == 1 ? iv[3:0] : 4'b0),
        .in_last(il[3:0]), .in_ready(r1), .sel(sel[1:0]), .out_data(od1), .out_valid(ov1),
        .out_last(ol1), .out_ready(ordy), .grant(g1), .busy(b1));
    mux_n_1_stream #(.N(5), .W(8), .MODE(2)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_data(id), .in_valid(m == 2 ? iv : 5'b0),
        .in_last(il), .in_ready(r2), .sel(sel), .out_data(od2), .out_valid(ov2),
        .out_last(ol2), .out_ready(ordy), .grant(g2), .busy(b2));

    always_comb begin
        od  = m == 0 ? od0 : m == 1 ? od1 : od2;
        ov  = m == 0 ? ov0 : m == 1 ? ov1 : ov2;
        ol  = m == 0 ? ol0 : m == 1 ? ol1 : ol2;
        bsy = m == 0 ? b0 : m == 1 ? b1 : b2;
        gnt = m == 0 ? {1'b0, g0} : m == 1 ? {1'b0, g1} : g2;
        rdy = m == 0 ? {1'b0, r0} : m == 1 ? {1'b0, r1} : r2;
    end

    int         tests = 0, fails = 0;
    logic [8:0] q[5][$];
    int         plen[5][$];
    int         hold[5];
    logic [8:0] exp_q[$], obs[$];
    int         exp_g[$], obs_g[$];
    bit         rq[$];
    bit         rnd, pb;
    int         selb;

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic add_pkt(int ch, int len, int base, bit rand_data);
        logic [7:0] d;
        for (int b = 0; b < len; b++) begin
            d = rand_data ? 8'($urandom) : 8'(base + b);
            q[ch].push_back({b == len - 1, d});
        end
        plen[ch].push_back(len);
    endtask

    // Packet-order model: every queued packet is requesting; pick by the mode rule, emit whole packet.
    task automatic build_exp(int mode, int n, int sv);
        int pi[5], pos[5];
        int ptr, g, c;
        exp_q.delete();
        exp_g.delete();
        for (int k = 0; k < 5; k++) begin pi[k] = 0; pos[k] = 0; end
        ptr = 0;
        while (1) begin
            g = -1;
            if (mode == 2) g = (sv < n && pi[sv] < plen[sv].size()) ? sv : -1;
            else for (int i = 0; i < n; i++) begin
                c = mode == 0 ? (ptr + i) % n : i;
                if (g < 0 && pi[c] < plen[c].size()) g = c;
            end
            if (g < 0) break;
            exp_g.push_back(g);
            for (int b = 0; b < plen[g][pi[g]]; b++) exp_q.push_back(q[g][pos[g] + b]);
            pos[g] += plen[g][pi[g]];
            pi[g]++;
            ptr = (g + 1) % n;
        end
    endtask

    task automatic step(int cyc);
        bit inf[5];
        bit outf;
        logic [8:0] ob;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            iv[k] = q[k].size() > 0 && cyc >= hold[k];
            id[k*8 +: 8] = q[k].size() > 0 ? q[k][0][7:0] : 8'h0;
            il[k] = q[k].size() > 0 && q[k][0][8];
        end
        ordy = rq.size() > 0 ? rq.pop_front() : (rnd ? $urandom_range(0, 3) != 0 : 1'b1);
        if (m == 2) sel = bsy ? 3'($urandom_range(0, 7)) : 3'(selb);
        #1;
        chk("rdy_onehot", 32'($countones(rdy) <= 1), 1);
        if (ov && !ordy) chk("rdy_backpressure", 32'(rdy), 0);
        if (bsy && !pb) obs_g.push_back(int'(gnt));
        pb = bsy;
        for (int k = 0; k < 5; k++) inf[k] = iv[k] && rdy[k];
        outf = ov && ordy;
        ob = {ol, od};
        @(posedge clk);
        for (int k = 0; k < 5; k++) if (inf[k]) void'(q[k].pop_front());
        if (outf) obs.push_back(ob);
    endtask

    task automatic run(int mode, int n, int budget, string tag);
        int cyc;
        build_exp(mode, n, selb);
        obs.delete();
        obs_g.delete();
        pb = 1'b0;
        cyc = 0;
        while (obs.size() < exp_q.size() && cyc < budget) begin step(cyc); cyc++; end
        chk({tag, "_timeout"}, 32'(cyc < budget), 1);
        for (int i = 0; i < 8; i++) step(cyc + i);
        chk({tag, "_beats"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
        chk({tag, "_npkts"}, obs_g.size(), exp_g.size());
        for (int i = 0; i < obs_g.size() && i < exp_g.size(); i++)
            chk($sformatf("%s_grant%0d", tag, i), obs_g[i], exp_g[i]);
        for (int k = 0; k < 5; k++) begin q[k].delete(); plen[k].delete(); hold[k] = 0; end
        rq.delete();
        iv = '0;
        il = '0;
    endtask

    task automatic rst();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iv = '0; il = '0; id = '0; ordy = 1'b1; sel = '0;
        m = 0; rnd = 1'b0; selb = 0; pb = 1'b0;
        for (int k = 0; k < 5; k++) hold[k] = 0;

        // reset with every channel valid, then arbitration/first-beat latency
        iv = 5'h1f;
        for (int k = 0; k < 5; k++) id[k*8 +: 8] = 8'(8'h10 + k);
        rst();
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_out_data", 32'(od), 0);
        chk("rst_out_last", 32'(ol), 0);
        chk("rst_grant", 32'(gnt), 0);
        chk("rst_busy", 32'(bsy), 0);
        chk("rst_in_ready", 32'(rdy), 0);
        @(posedge clk); #1;
        chk("edge1_busy", 32'(bsy), 1);
        chk("edge1_grant", 32'(gnt), 0);
        chk("edge1_out_valid", 32'(ov), 0);
        @(posedge clk); #1;
        chk("edge2_out_valid", 32'(ov), 1);
        chk("edge2_out_data", 32'(od), 32'h10);
        iv = '0;

        // round-robin fairness: grant order 0,1,2,3,0
        rst();
        add_pkt(0, 2, 0, 1); add_pkt(0, 2, 0, 1);
        for (int k = 1; k < 4; k++) add_pkt(k, 2, 0, 1);
        run(0, 4, 200, "rr");

        rst();
        rnd = 1'b1;
        for (int k = 0; k < 4; k++) repeat ($urandom_range(1, 3)) add_pkt(k, $urandom_range(1, 4), 0, 1);
        run(0, 4, 1000, "rr_rand");
        rnd = 1'b0;

        // fixed priority: channel 1 before channel 3
        m = 1;
        rst();
        add_pkt(3, 3, 8'h30, 0); add_pkt(1, 3, 8'h10, 0);
        run(1, 4, 200, "fixed");

        rst();
        rnd = 1'b1;
        for (int k = 0; k < 4; k++) repeat ($urandom_range(1, 3)) add_pkt(k, $urandom_range(1, 4), 0, 1);
        run(1, 4, 1000, "fixed_rand");
        rnd = 1'b0;

        // packet lock: channel 2 requests mid-packet of channel 0
        m = 0;
        rst();
        add_pkt(0, 5, 8'h50, 0); add_pkt(2, 2, 8'h20, 0);
        hold[2] = 3;
        run(0, 4, 200, "lock");

        // backpressure during a 4-beat packet
        rst();
        add_pkt(0, 4, 8'hA0, 0);
        rq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run(0, 4, 100, "bp");

        // external select: out-of-range values never request
        m = 2;
        rst();
        iv = 5'h1f;
        for (int s = 5; s < 8; s++) begin
            sel = 3'(s);
            repeat (2) @(negedge clk);
            chk($sformatf("sel%0d_busy", s), 32'(bsy), 0);
            chk($sformatf("sel%0d_in_ready", s), 32'(rdy), 0);
            chk($sformatf("sel%0d_out_valid", s), 32'(ov), 0);
        end
        iv = '0;

        // external select stream with sel scrambled while locked
        rst();
        selb = 2;
        rnd = 1'b1;
        add_pkt(2, 3, 0, 1); add_pkt(1, 2, 0, 1); add_pkt(2, 1, 0, 1);
        run(2, 5, 300, "sel");
        rnd = 1'b0;

        // reset mid-packet discards output and lock, then re-arbitrates
        rst();
        sel = 3'd2; iv = 5'b00100; il = '0; id[23:16] = 8'h55; ordy = 1'b1;
        for (int i = 0; i < 10 && !ov; i++) @(negedge clk);
        chk("mid_out_valid", 32'(ov), 1);
        sel = 3'd3;
        @(negedge clk);
        chk("mid_sel_change_grant", 32'(gnt), 2);
        chk("mid_sel_change_busy", 32'(bsy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(ov), 0);
        chk("mid_rst_busy", 32'(bsy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 3'd2;
        @(posedge clk); #1;
        chk("rearb_busy", 32'(bsy), 1);
        chk("rearb_grant", 32'(gnt), 2);
        iv = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
